// File: rtl/ram_dma_copy_pkg.sv
// Shared constants for the RAM copy engine: state encoding and RAM window bounds.
package ram_dma_copy_pkg;

  localparam logic [15:0] RAM_BOUND_L = 16'h0200;
  localparam logic [15:0] RAM_BOUND_U = 16'h0400;
  localparam int          DMA_LEN_W   = 10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    READ  = 3'd2,
    WRITE = 3'd3,
    FIN   = 3'd4
  } state_t;

endpackage

// File: rtl/ram_dma_copy_range_chk.sv
// Combinational alignment/bounds checker for one transfer region (src or dst).
module ram_dma_range_chk #(
  parameter logic [15:0] LO = ram_dma_copy_pkg::RAM_BOUND_L,
  parameter logic [15:0] HI = ram_dma_copy_pkg::RAM_BOUND_U,
  parameter int          LW = ram_dma_copy_pkg::DMA_LEN_W
) (
  input  logic [15:0]   i_addr,
  input  logic [LW-1:0] i_len,
  input  logic          i_bw,
  output logic          o_err
);

  logic [16:0] w_span;
  logic [16:0] w_end;

  // 17-bit so a region ending past 0xFFFF cannot wrap back into range
  assign w_span = i_bw ? {{(17-LW){1'b0}}, i_len} : {{(16-LW){1'b0}}, i_len, 1'b0};
  assign w_end  = {1'b0, i_addr} + w_span;
  assign o_err  = (!i_bw && i_addr[0]) || (i_addr < LO) || (w_end > {1'b0, HI});

endmodule

// File: rtl/ram_dma_copy.sv
// RAM-to-RAM block copy initiator, 2 cycles per unit. Optional fill mode
// (1 unit per cycle, constant data) is built when RAM_DMA_FILL_EN is defined.
//
// state | meaning
// IDLE  | waiting for start, request fields latched on start
// CHECK | alignment/bounds check of the latched request
// READ  | RAM read at src, data captured at the edge
// WRITE | RAM write at dst, pointers advance
// FIN   | one-cycle done pulse
module ram_dma_copy #(
  parameter logic [15:0] BOUND_L = ram_dma_copy_pkg::RAM_BOUND_L,
  parameter logic [15:0] BOUND_U = ram_dma_copy_pkg::RAM_BOUND_U,
  parameter int          LEN_W   = ram_dma_copy_pkg::DMA_LEN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [15:0]      src_addr,
  input  logic [15:0]      dst_addr,
  input  logic [LEN_W-1:0] xfer_len,
  input  logic             xfer_bw,
  input  logic             abort,
`ifdef RAM_DMA_FILL_EN
  input  logic             fill_mode,
  input  logic [15:0]      fill_data,
`endif
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [15:0]      ram_addr,
  output logic [15:0]      ram_Din,
  output logic             ram_RW,
  output logic             BW,
  input  logic [15:0]      ram_out
);
  import ram_dma_copy_pkg::*;

  state_t           r_state, w_next;
  logic [15:0]      r_src, r_dst, r_data;
  logic [LEN_W-1:0] r_rem;
  logic             r_bw, r_abort;
  logic             w_fill, w_src_err, w_dst_err, w_chk_err, w_last;
  logic [15:0]      w_size, w_wdata;

`ifdef RAM_DMA_FILL_EN
  logic             r_fill;
  logic [15:0]      r_fill_data;
  assign w_fill  = r_fill;
  assign w_wdata = r_fill ? (r_bw ? {8'h00, r_fill_data[7:0]} : r_fill_data) : r_data;
`else
  assign w_fill  = 1'b0;
  assign w_wdata = r_data;
`endif

  ram_dma_range_chk #(.LO(BOUND_L), .HI(BOUND_U), .LW(LEN_W)) u_src_chk (
    .i_addr(r_src), .i_len(r_rem), .i_bw(r_bw), .o_err(w_src_err)
  );
  ram_dma_range_chk #(.LO(BOUND_L), .HI(BOUND_U), .LW(LEN_W)) u_dst_chk (
    .i_addr(r_dst), .i_len(r_rem), .i_bw(r_bw), .o_err(w_dst_err)
  );

  assign w_chk_err = (w_src_err && !w_fill) || w_dst_err;
  assign w_size    = r_bw ? 16'd1 : 16'd2;
  assign w_last    = (r_rem == LEN_W'(1)) || abort || r_abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_src   <= '0;
      r_dst   <= '0;
      r_data  <= '0;
      r_rem   <= '0;
      r_bw    <= 1'b0;
      r_abort <= 1'b0;
`ifdef RAM_DMA_FILL_EN
      r_fill      <= 1'b0;
      r_fill_data <= '0;
`endif
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          r_abort <= 1'b0;
          if (start) begin
            r_src <= src_addr;
            r_dst <= dst_addr;
            r_rem <= xfer_len;
            r_bw  <= xfer_bw;
`ifdef RAM_DMA_FILL_EN
            r_fill      <= fill_mode;
            r_fill_data <= fill_data;
`endif
          end
        end
        READ: begin
          r_data <= r_bw ? {8'h00, ram_out[7:0]} : ram_out;
          if (abort) r_abort <= 1'b1;
        end
        WRITE: begin
          r_src <= r_src + w_size;
          r_dst <= r_dst + w_size;
          r_rem <= r_rem - LEN_W'(1);
          if (abort) r_abort <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next   = r_state;
    busy     = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    ram_addr = '0;
    ram_Din  = '0;
    ram_RW   = 1'b0;
    BW       = 1'b1;
    case (r_state)
      IDLE: if (start) w_next = CHECK;
      CHECK: begin
        busy = 1'b1;
        if (w_chk_err) begin
          err    = 1'b1;
          w_next = IDLE;
        end else if (r_rem == '0) w_next = FIN;
        else if (w_fill)          w_next = WRITE;
        else                      w_next = READ;
      end
      READ: begin
        busy     = 1'b1;
        ram_addr = r_src - BOUND_L;
        BW       = r_bw;
        w_next   = WRITE;
      end
      WRITE: begin
        busy     = 1'b1;
        ram_addr = r_dst - BOUND_L;
        ram_Din  = w_wdata;
        ram_RW   = 1'b1;
        BW       = r_bw;
        if (w_last)      w_next = FIN;
        else if (w_fill) w_next = WRITE;
        else             w_next = READ;
      end
      FIN: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ram_dma_copy.sv
// Directed bench for ram_dma_copy with a byte-addressed RAM model (512 bytes at
// offset 0 = absolute 0x0200). Exercises fill mode when RAM_DMA_FILL_EN is defined.
module tb_ram_dma_copy;

  logic        clk, rst_n, start, xfer_bw, abort;
  logic [15:0] src_addr, dst_addr;
  logic [9:0]  xfer_len;
  logic        busy, done, err, ram_RW, BW;
  logic [15:0] ram_addr, ram_Din, ram_out;
`ifdef RAM_DMA_FILL_EN
  logic        fill_mode;
  logic [15:0] fill_data;
`endif

  logic [7:0]  mem [0:511];
  logic [8:0]  w_a;
  int          wr_cnt = 0;
  int          n_vec  = 0;
  int          n_mis  = 0;

  ram_dma_copy dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr),
    .xfer_len(xfer_len), .xfer_bw(xfer_bw), .abort(abort),
`ifdef RAM_DMA_FILL_EN
    .fill_mode(fill_mode), .fill_data(fill_data),
`endif
    .busy(busy), .done(done), .err(err),
    .ram_addr(ram_addr), .ram_Din(ram_Din), .ram_RW(ram_RW), .BW(BW),
    .ram_out(ram_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign w_a     = ram_addr[8:0];
  assign ram_out = BW ? {8'h00, mem[w_a]} : {mem[w_a + 9'd1], mem[w_a]};

  always @(posedge clk) begin
    if (ram_RW) begin
      mem[w_a] <= ram_Din[7:0];
      if (!BW) mem[w_a + 9'd1] <= ram_Din[15:8];
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // cyc counts edges after the start-sampling edge; cyc==1 is the CHECK cycle
  task automatic xfer(input logic [15:0] s, input logic [15:0] d, input logic [9:0] l,
                      input logic b, input int ab_at, input int st_at,
                      output int cyc, output int wr, output logic e, output logic bz);
    int   w0;
    logic fin;
    w0 = wr_cnt;
    src_addr = s; dst_addr = d; xfer_len = l; xfer_bw = b;
    start = 1'b1; cyc = 0; e = 1'b0; fin = 1'b0; bz = 1'b1;
    while (!fin && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      start = (cyc == st_at);
      abort = (cyc == ab_at);
      if (err) e = 1'b1;
      if (done || err) begin
        fin = 1'b1;
        bz  = busy;
      end
    end
    start = 1'b0; abort = 1'b0;
    wr = wr_cnt - w0;
    @(posedge clk); #1;
  endtask

  int          cyc, wr, w0, k;
  logic        e, bz;
  logic [7:0]  pat [0:7];

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 8'hEE;
    for (int i = 0; i < 8; i++) begin
      pat[i] = 8'((i + 1) * 8'h11);
      mem[i] = pat[i];
    end
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; xfer_bw = 1'b0;
    src_addr = '0; dst_addr = '0; xfer_len = '0;
`ifdef RAM_DMA_FILL_EN
    fill_mode = 1'b0; fill_data = '0;
`endif
    #3;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_rw", ram_RW, 1'b0);
    chk("rst_addr", ram_addr, 16'h0000);
    chk("rst_din", ram_Din, 16'h0000);
    chk("rst_bw", BW, 1'b1);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // word copy 0x0200 -> 0x0300, 4 words
    xfer(16'h0200, 16'h0300, 10'd4, 1'b0, -1, -1, cyc, wr, e, bz);
    chk("wcopy_lat", cyc, 10);
    chk("wcopy_wr", wr, 4);
    chk("wcopy_err", e, 1'b0);
    chk("wcopy_busy_at_done", bz, 1'b0);
    for (int i = 0; i < 8; i++) chk("wcopy_data", mem[9'h100 + 9'(i)], pat[i]);
    chk("wcopy_tail", mem[9'h108], 8'hEE);

    // byte copy at odd addresses 0x0201 -> 0x0351, 3 bytes
    xfer(16'h0201, 16'h0351, 10'd3, 1'b1, -1, -1, cyc, wr, e, bz);
    chk("bcopy_lat", cyc, 8);
    chk("bcopy_wr", wr, 3);
    chk("bcopy_d0", mem[9'h151], 8'h22);
    chk("bcopy_d1", mem[9'h152], 8'h33);
    chk("bcopy_d2", mem[9'h153], 8'h44);
    chk("bcopy_below", mem[9'h150], 8'hEE);
    chk("bcopy_above", mem[9'h154], 8'hEE);

    // misaligned word source
    xfer(16'h0201, 16'h0300, 10'd1, 1'b0, -1, -1, cyc, wr, e, bz);
    chk("odd_src_err", e, 1'b1);
    chk("odd_src_lat", cyc, 1);
    chk("odd_src_wr", wr, 0);

    // destination runs past BOUND_U by one word
    xfer(16'h0200, 16'h03FE, 10'd2, 1'b0, -1, -1, cyc, wr, e, bz);
    chk("dst_over_err", e, 1'b1);
    chk("dst_over_wr", wr, 0);

    // last word below BOUND_U is legal
    xfer(16'h0200, 16'h03FE, 10'd1, 1'b0, -1, -1, cyc, wr, e, bz);
    chk("dst_edge_err", e, 1'b0);
    chk("dst_edge_lat", cyc, 4);
    chk("dst_edge_lo", mem[9'h1FE], 8'h11);
    chk("dst_edge_hi", mem[9'h1FF], 8'h22);

    // source below BOUND_L
    xfer(16'h01FE, 16'h0300, 10'd1, 1'b0, -1, -1, cyc, wr, e, bz);
    chk("src_under_err", e, 1'b1);

    // zero length
    xfer(16'h0200, 16'h0300, 10'd0, 1'b0, -1, -1, cyc, wr, e, bz);
    chk("len0_lat", cyc, 2);
    chk("len0_wr", wr, 0);
    chk("len0_err", e, 1'b0);

    // abort during second READ, plus a start pulse while busy
    xfer(16'h0200, 16'h03A0, 10'd8, 1'b0, 4, 2, cyc, wr, e, bz);
    chk("abort_lat", cyc, 6);
    chk("abort_wr", wr, 2);
    chk("abort_d0", mem[9'h1A0], 8'h11);
    chk("abort_d3", mem[9'h1A3], 8'h44);
    chk("abort_untouched", mem[9'h1A4], 8'hEE);
    w0 = wr_cnt;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_idle_busy", busy, 1'b0);
    chk("abort_idle_wr", wr_cnt - w0, 0);

    // async reset while a write is being driven
    src_addr = 16'h0200; dst_addr = 16'h0380; xfer_len = 10'd4; xfer_bw = 1'b0;
    start = 1'b1;
    k = 0;
    w0 = wr_cnt;
    while (!ram_RW && k < 20) begin
      @(posedge clk); #1;
      start = 1'b0;
      k++;
    end
    chk("rst_saw_rw", ram_RW, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_rw", ram_RW, 1'b0);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_addr", ram_addr, 16'h0000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_nowrite", wr_cnt - w0, 0);
    chk("rst_mid_mem", mem[9'h180], 8'hEE);

`ifdef RAM_DMA_FILL_EN
    fill_mode = 1'b1; fill_data = 16'hA5A5;
    xfer(16'h0000, 16'h0380, 10'd4, 1'b0, -1, -1, cyc, wr, e, bz);
    fill_mode = 1'b0;
    chk("post_rst_lat", cyc, 6);
    chk("post_rst_wr", wr, 4);
    for (int i = 0; i < 8; i++) chk("post_rst_data", mem[9'h180 + 9'(i)], 8'hA5);
`else
    xfer(16'h0200, 16'h0380, 10'd4, 1'b0, -1, -1, cyc, wr, e, bz);
    chk("post_rst_lat", cyc, 10);
    chk("post_rst_wr", wr, 4);
    for (int i = 0; i < 8; i++) chk("post_rst_data", mem[9'h180 + 9'(i)], pat[i]);
`endif
    chk("post_rst_tail", mem[9'h188], 8'hEE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
